// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one bit position per clock, start/done handshake,
// C/V/Z/N status flags registered alongside the result.
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             V,
    output logic             Z,
    output logic             N
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    state_t             state_reg;
    logic [AMT_W-1:0]   count_reg;
    logic [WIDTH-1:0]   work_reg;
    logic [1:0]         mode_reg;
    logic               carry_reg;
    logic               ovf_reg;

    logic               ready_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   y_reg;
    logic               c_reg;
    logic               v_reg;
    logic               z_reg;
    logic               n_reg;

    // One-bit step network
    logic [WIDTH-1:0]   shl_next;
    logic [WIDTH-1:0]   shr_next;
    logic [WIDTH-1:0]   work_next;
    logic               fill_bit;
    logic               carry_next;
    logic               ovf_next;

    always_comb begin
        fill_bit = 1'b0;
        unique case (mode_reg)
            MODE_ASR: fill_bit = work_reg[WIDTH-1];
            MODE_ROR: fill_bit = work_reg[0];
            default:  fill_bit = 1'b0;
        endcase
    end

    assign shl_next[0]       = 1'b0;
    assign shr_next[WIDTH-1] = fill_bit;

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_step
            assign shl_next[gi+1] = work_reg[gi];
            assign shr_next[gi]   = work_reg[gi+1];
        end
    endgenerate

    assign work_next  = (mode_reg == MODE_LSL) ? shl_next : shr_next;
    assign carry_next = (mode_reg == MODE_LSL) ? work_reg[WIDTH-1] : work_reg[0];
    // Signed overflow: the sign bit flips when the two top bits differ before the step
    assign ovf_next   = (mode_reg == MODE_LSL) && (work_reg[WIDTH-1] != work_reg[WIDTH-2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            work_reg  <= '0;
            mode_reg  <= MODE_LSL;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
            y_reg     <= '0;
            c_reg     <= 1'b0;
            v_reg     <= 1'b0;
            z_reg     <= 1'b0;
            n_reg     <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        count_reg <= amt;
                        work_reg  <= A;
                        mode_reg  <= mode;
                        carry_reg <= 1'b0;
                        ovf_reg   <= 1'b0;
                        ready_reg <= 1'b0;
                        state_reg <= SHIFT;
                    end else begin
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    // Exhausted count spends one edge publishing result and flags
                    if (count_reg == '0) begin
                        y_reg     <= work_reg;
                        c_reg     <= carry_reg;
                        v_reg     <= ovf_reg;
                        z_reg     <= (work_reg == '0);
                        n_reg     <= work_reg[WIDTH-1];
                        done_reg  <= 1'b1;
                        ready_reg <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        work_reg  <= work_next;
                        carry_reg <= carry_next;
                        ovf_reg   <= ovf_reg | ovf_next;
                        count_reg <= count_reg - AMT_W'(1);
                    end
                end
                default: begin
                    ready_reg <= 1'b1;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_reg;
    assign done  = done_reg;
    assign Y     = y_reg;
    assign C     = c_reg;
    assign V     = v_reg;
    assign Z     = z_reg;
    assign N     = n_reg;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: driver pushes expected results from a
// behavioural model, an independent monitor pops and checks on each done pulse.
module tb_seq_shifter;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  A;
    logic [AW-1:0] amt;
    logic [1:0]    mode;
    logic          ready, done;
    logic [W-1:0]  Y;
    logic          C, V, Z, N;

    seq_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .amt(amt), .mode(mode),
        .ready(ready), .done(done), .Y(Y), .C(C), .V(V), .Z(Z), .N(N)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        logic         c, v, z, n;
        int           exp_cyc;
        int           id;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   txn_id = 0;
    bit   noise_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: shift semantics stated arithmetically on the whole operand
    function automatic exp_t model(input logic [W-1:0] a, input logic [1:0] m, input int k);
        exp_t e;
        logic [31:0]         wide;
        logic signed [W-1:0] sa;
        int                  r;
        logic                b0, bk;
        e.c = 1'b0;
        e.v = 1'b0;
        unique case (m)
            2'b00: begin
                wide = {24'd0, a} << k;
                e.y  = wide[W-1:0];
                if (k > 0 && k <= W) e.c = a[W-k];
                b0 = a[W-1];
                for (int i = 1; i <= k; i++) begin
                    bk = (W - 1 - i >= 0) ? a[W-1-i] : 1'b0;
                    if (bk != b0) e.v = 1'b1;
                end
            end
            2'b01: begin
                e.y = a >> k;
                if (k > 0 && k <= W) e.c = a[k-1];
            end
            2'b10: begin
                sa  = a;
                e.y = sa >>> k;
                if (k > 0) e.c = (k <= W) ? a[k-1] : a[W-1];
            end
            default: begin
                r    = k % W;
                wide = ({24'd0, a} >> r) | ({24'd0, a} << (W - r));
                e.y  = wide[W-1:0];
                if (k > 0) e.c = e.y[W-1];
            end
        endcase
        e.z = (e.y == '0);
        e.n = e.y[W-1];
        e.exp_cyc = 0;
        e.id = 0;
        return e;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0 || Y !== '0 || C !== 1'b0 ||
            V !== 1'b0 || Z !== 1'b0 || N !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got ready=%b done=%b Y=%h C=%b V=%b Z=%b N=%b expected 1 0 00 0 0 0 0",
                     tag, ready, done, Y, C, V, Z, N);
        end else
            $display("reset check %s ok", tag);
    endtask

    // Waits for ready (spraying ignored starts while busy), then issues one op
    task automatic issue(input logic [W-1:0] a, input logic [1:0] m, input int k);
        exp_t e;
        int   t = 0;
        while (!ready && t < 100) begin
            if (noise_en && ($urandom_range(0, 1) == 1)) begin
                start = 1'b1;
                A     = 8'h33;
                amt   = AW'($urandom_range(0, 15));
                mode  = 2'($urandom_range(0, 3));
            end else
                start = 1'b0;
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            miscompares++;
            $display("FAIL ready_timeout: got ready=%b expected 1 within 100 cycles", ready);
            start = 1'b0;
            return;
        end
        start = 1'b1;
        A     = a;
        amt   = AW'(k);
        mode  = m;
        e = model(a, m, k);
        e.exp_cyc = cyc + 1 + k + 1;
        e.id = txn_id++;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A     = $urandom();
        amt   = AW'($urandom_range(0, 15));
        mode  = 2'($urandom_range(0, 3));
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_done: got done=1 at cycle %0d expected no pending op", cyc);
                end else begin
                    e = exp_q.pop_front();
                    vectors++;
                    if (Y !== e.y || C !== e.c || V !== e.v || Z !== e.z || N !== e.n || cyc != e.exp_cyc) begin
                        miscompares++;
                        $display("FAIL txn%0d: got Y=%h C=%b V=%b Z=%b N=%b cyc=%0d expected Y=%h C=%b V=%b Z=%b N=%b cyc=%0d",
                                 e.id, Y, C, V, Z, N, cyc, e.y, e.c, e.v, e.z, e.n, e.exp_cyc);
                    end else
                        $display("txn%0d Y=%h C=%b V=%b Z=%b N=%b cyc=%0d", e.id, Y, C, V, Z, N, cyc);
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].exp_cyc) begin
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL done_timeout txn%0d: got no done by cycle %0d expected at %0d", e.id, cyc, e.exp_cyc);
            end
        end
    end

    initial begin
        int t;
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        amt   = '0;
        mode  = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("after_reset");
        reset = 1'b0;

        // Abort an amt=5 op two cycles in
        issue(8'hA5, 2'b00, 5);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("abort");
        check_bit("abort_no_done", done, 1'b0);
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check_bit("abort_stays_quiet", done, 1'b0);
        end

        issue(8'h81, 2'b00, 1);
        issue(8'h90, 2'b10, 3);
        issue(8'h01, 2'b01, 1);
        issue(8'h01, 2'b11, 9);
        issue(8'hFF, 2'b00, 9);
        issue(8'h5A, 2'b01, 0);
        issue(8'h80, 2'b10, 15);
        issue(8'hC3, 2'b11, 8);
        issue(8'h80, 2'b00, 8);
        issue(8'h01, 2'b01, 8);
        noise_en = 1'b1;
        issue(8'h6C, 2'b00, 4);
        issue(8'h6C, 2'b11, 4);

        for (int i = 0; i < 200; i++)
            issue(8'($urandom()), 2'($urandom_range(0, 3)), $urandom_range(0, 15));

        t = 0;
        while (exp_q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending ops expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
